// File: rtl/ex_ls_pipe_reg_pkg.sv
// Shared widths, control-code constants and FSM state encodings for the
// EX -> load/store pipeline register.
package ex_ls_pipe_reg_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_CTL_W  = 4;
   localparam int DEF_RD_W   = 5;

   localparam logic [DEF_CTL_W-1:0] LS_CTL_NONE = 4'b0000;
   localparam int                   LS_LOAD_BIT = 3;

   // Encoding is {main_v, skid_v}; 2'b01 is unreachable.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } state_e;

endpackage

// File: rtl/ex_ls_slot.sv
// Payload register with load enable and asynchronous active-low clear; one
// instance per skid-buffer entry.
module ex_ls_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // NOTE: payload is cleared on reset so every ls_* output reads zero while
   // reset is asserted; the enable keeps an idle EX bus from ever loading X.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/ex_ls_pipe_reg.sv
// EX -> load/store pipeline register built as a two-entry skid buffer so that
// ex_ready depends only on local state, never on ls_ready.
module ex_ls_pipe_reg
   import ex_ls_pipe_reg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTL_W  = DEF_CTL_W,
   parameter int RD_W   = DEF_RD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] ex_alu_res,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [CTL_W-1:0]  ex_ls_ctl,
   input  logic [RD_W-1:0]   ex_rd,
   input  logic              ex_rd_we,
   input  logic [DATA_W-1:0] ex_pc,
   output logic              ls_valid,
   input  logic              ls_ready,
   output logic [DATA_W-1:0] ls_alu_res,
   output logic [DATA_W-1:0] ls_store_data,
   output logic [CTL_W-1:0]  ls_ls_ctl,
   output logic [RD_W-1:0]   ls_rd,
   output logic              ls_rd_we,
   output logic [DATA_W-1:0] ls_pc,
   output logic              ls_is_load
);

   localparam int PL_W = 3 * DATA_W + CTL_W + RD_W + 1;

   state_e            r_state;
   state_e            w_state_nxt;
   logic              w_main_v;
   logic              w_skid_v;
   logic              w_acc;
   logic              w_pop;
   logic              w_main_ld;
   logic              w_main_from_skid;
   logic              w_skid_ld;
   logic [PL_W-1:0]   w_ex_pl;
   logic [PL_W-1:0]   w_main_d;
   logic [PL_W-1:0]   w_main_q;
   logic [PL_W-1:0]   w_skid_q;

   logic [DATA_W-1:0] w_alu_res;
   logic [DATA_W-1:0] w_store_data;
   logic [CTL_W-1:0]  w_ls_ctl;
   logic [RD_W-1:0]   w_rd;
   logic              w_rd_we;
   logic [DATA_W-1:0] w_pc;

   assign w_main_v = (r_state == ST_ONE) || (r_state == ST_FULL);
   assign w_skid_v = (r_state == ST_FULL);

   assign ex_ready = ~w_skid_v;
   assign ls_valid = w_main_v;
   assign w_acc    = ex_valid & ex_ready;
   assign w_pop    = w_main_v & ls_ready;

   // NOTE: state register uses non-blocking assignment; next-state logic is
   // computed separately in always_comb.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_main_ld        = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_ld        = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         unique case (r_state)
            ST_EMPTY: begin
               if (w_acc) begin
                  w_state_nxt = ST_ONE;
                  w_main_ld   = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_acc && w_pop) begin
                  w_main_ld = 1'b1;
               end else if (w_acc) begin
                  w_state_nxt = ST_FULL;
                  w_skid_ld   = 1'b1;
               end else if (w_pop) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // ex_ready is low here, so only the skid-to-main shift can happen.
               if (w_pop) begin
                  w_state_nxt      = ST_ONE;
                  w_main_ld        = 1'b1;
                  w_main_from_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   assign w_ex_pl  = {ex_alu_res, ex_store_data, ex_ls_ctl, ex_rd, ex_rd_we, ex_pc};
   assign w_main_d = w_main_from_skid ? w_skid_q : w_ex_pl;

   ex_ls_slot #(.W(PL_W)) u_main (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_main_ld),
      .i_d    (w_main_d),
      .o_q    (w_main_q)
   );

   ex_ls_slot #(.W(PL_W)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_skid_ld),
      .i_d    (w_ex_pl),
      .o_q    (w_skid_q)
   );

   assign {w_alu_res, w_store_data, w_ls_ctl, w_rd, w_rd_we, w_pc} = w_main_q;

   // Stale payload may survive a flush; mask the fields that trigger side effects.
   assign ls_alu_res    = w_alu_res;
   assign ls_store_data = w_store_data;
   assign ls_ls_ctl     = w_main_v ? w_ls_ctl : CTL_W'(LS_CTL_NONE);
   assign ls_rd         = w_rd;
   assign ls_rd_we      = w_main_v & w_rd_we;
   assign ls_pc         = w_pc;
   assign ls_is_load    = w_main_v & w_ls_ctl[LS_LOAD_BIT];

endmodule
